// File: rtl/mio_bus_pkg.sv
// Shared encodings and address-slice positions for the memory/IO bus controller.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DBG  = 2'b10
  } grant_t;

  // Any address whose top nibble is at or above this value lands in the IO region.
  localparam logic [3:0] IO_NIBBLE = 4'hE;

  localparam int RAM_IDX_LSB = 2;
  localparam int RAM_IDX_MSB = 11;
  localparam int IO_IDX_LSB  = 2;
  localparam int IO_IDX_MSB  = 7;
  localparam int RAM_AW      = RAM_IDX_MSB - RAM_IDX_LSB + 1;
  localparam int IO_AW       = IO_IDX_MSB - IO_IDX_LSB + 1;
  localparam int WAIT_W      = 4;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational region select and word-index extraction for a byte address.
module mio_addr_decode
  import mio_bus_pkg::*;
(
  input  logic [31:0]       addr,
  output logic              is_io,
  output logic [RAM_AW-1:0] ram_idx,
  output logic [IO_AW-1:0]  io_idx
);

  assign is_io   = (addr[31:28] >= IO_NIBBLE);
  assign ram_idx = addr[RAM_IDX_MSB:RAM_IDX_LSB];
  assign io_idx  = addr[IO_IDX_MSB:IO_IDX_LSB];

  // Middle address bits and the byte offset carry no meaning in this map.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[27:RAM_IDX_MSB+1], addr[RAM_IDX_LSB-1:0]};

endmodule

// File: rtl/mio_bus_ctrl.sv
// Two-master (CPU read/write, debug read-only) bus controller with round-robin
// arbitration, RAM/IO region decode and per-region wait states.
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_sel,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  output logic [1:0]        grant,
  output logic [1:0]        state_out
);

  localparam logic [WAIT_W-1:0] RAM_WAIT_L = WAIT_W'(RAM_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_L  = WAIT_W'(IO_WAIT);

  state_t            state;
  grant_t            grant_q;
  grant_t            last_grant;
  grant_t            next_owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       rdata_q;
  logic [31:0]       wdata_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [IO_AW-1:0]  io_addr_q;
  logic              io_sel_q;
  logic              ram_we_q;
  logic              io_we_q;
  logic              cpu_ready_q;
  logic              dbg_ready_q;

  logic [31:0]       sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;
  logic              dec_is_io;
  logic [RAM_AW-1:0] dec_ram_idx;
  logic [IO_AW-1:0]  dec_io_idx;

  // On a tie the master that did not own the previous transaction wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_owner = GNT_NONE;
    if (cpu_req && dbg_req) begin
      next_owner = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (cpu_req) begin
      next_owner = GNT_CPU;
    end else if (dbg_req) begin
      next_owner = GNT_DBG;
    end
  end

  // The debug master is read-only, so its write enable and data are tied off.
  always_comb begin
    sel_addr  = dbg_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (next_owner == GNT_CPU) begin
      sel_addr  = cpu_addr;
      sel_we    = cpu_we;
      sel_wdata = cpu_wdata;
    end
  end

  mio_addr_decode u_decode (
    .addr    (sel_addr),
    .is_io   (dec_is_io),
    .ram_idx (dec_ram_idx),
    .io_idx  (dec_io_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_q     <= GNT_NONE;
      last_grant  <= GNT_DBG;
      wait_cnt    <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      io_addr_q   <= '0;
      io_sel_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      io_we_q     <= 1'b0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      io_we_q     <= 1'b0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (next_owner != GNT_NONE) begin
            state      <= ST_ACCESS;
            grant_q    <= next_owner;
            ram_addr_q <= dec_ram_idx;
            io_addr_q  <= dec_io_idx;
            wdata_q    <= sel_wdata;
            io_sel_q   <= dec_is_io;
            ram_we_q   <= sel_we & ~dec_is_io;
            io_we_q    <= sel_we & dec_is_io;
            wait_cnt   <= dec_is_io ? IO_WAIT_L : RAM_WAIT_L;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            // io_sel_q still holds the latched region in this last ACCESS cycle.
            rdata_q     <= io_sel_q ? io_rdata : ram_rdata;
            io_sel_q    <= 1'b0;
            state       <= ST_DONE;
            cpu_ready_q <= (grant_q == GNT_CPU);
            dbg_ready_q <= (grant_q == GNT_DBG);
          end
        end
        ST_DONE: begin
          last_grant <= grant_q;
          grant_q    <= GNT_NONE;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign io_sel    = io_sel_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = wdata_q;
  assign grant     = grant_q;
  assign state_out = state;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench: two controller instances (default waits and RAM_WAIT=2/IO_WAIT=3)
// with behavioural RAM/IO models; expectations come from a transaction-level reference model.
module tb_mio_bus_ctrl;

  localparam int OWN_CPU = 1;
  localparam int OWN_DBG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          sel;
  logic        cpu_req, cpu_we, dbg_req;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr;

  wire [31:0] cpu_rdata [2];
  wire        cpu_ready [2];
  wire [31:0] dbg_rdata [2];
  wire        dbg_ready [2];
  wire [9:0]  ram_addr  [2];
  wire        ram_we    [2];
  wire [31:0] ram_wdata [2];
  wire        io_sel    [2];
  wire        io_we     [2];
  wire [5:0]  io_addr   [2];
  wire [31:0] io_wdata  [2];
  wire [1:0]  grant     [2];
  wire [1:0]  state_out [2];

  logic [31:0] ref_ram [1024];
  logic [31:0] ref_io  [64];
  int          last_owner;
  int          tests_run    = 0;
  int          tests_failed = 0;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int ram_wait_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int io_wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] ram_mem [1024];
    logic [31:0] io_mem  [64];
    logic [31:0] ram_q;
    wire  [31:0] io_q;

    mio_bus_ctrl #(.RAM_WAIT(g == 0 ? 1 : 2), .IO_WAIT(g == 0 ? 0 : 3)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req && (sel == g)),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .dbg_req   (dbg_req && (sel == g)),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata[g]),
      .dbg_ready (dbg_ready[g]),
      .ram_addr  (ram_addr[g]),
      .ram_we    (ram_we[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_q),
      .io_sel    (io_sel[g]),
      .io_we     (io_we[g]),
      .io_addr   (io_addr[g]),
      .io_wdata  (io_wdata[g]),
      .io_rdata  (io_q),
      .grant     (grant[g]),
      .state_out (state_out[g])
    );

    // Synchronous-read block RAM and combinational-read register file.
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 1024; i++) ram_mem[i] <= pat(i);
        for (int i = 0; i < 64; i++) io_mem[i] <= pat(i + 4096);
      end else begin
        if (ram_we[g]) ram_mem[ram_addr[g]] <= ram_wdata[g];
        if (io_we[g]) io_mem[io_addr[g]] <= io_wdata[g];
      end
      ram_q <= ram_mem[ram_addr[g]];
    end
    assign io_q = io_mem[io_addr[g]];
  end

  task automatic ref_init();
    for (int i = 0; i < 1024; i++) ref_ram[i] = pat(i);
    for (int i = 0; i < 64; i++) ref_io[i] = pat(i + 4096);
    last_owner = OWN_DBG;
  endtask

  task automatic apply_reset(input int d);
    sel = d;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ref_init();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[31:28] = 4'($urandom_range(14, 15));
    else a[31:28] = 4'($urandom_range(0, 13));
    a[11:2] = 10'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: a = 32'hDFFF_F004;
      1: a = 32'hE000_0004;
      default: ;
    endcase
    return a;
  endfunction

  // One transaction from an idle controller; requests drop in cycle 1.
  task automatic run_single(input int d, input bit c_on, input bit g_on, input bit we,
                            input logic [31:0] c_addr, input logic [31:0] g_addr,
                            input logic [31:0] wd, input string tag);
    int          owner, w, idx;
    bit          is_io, eff_we;
    logic [31:0] addr, exp_rd, got_wd;
    logic [8:0]  obs, exp_v;
    if (c_on && g_on) owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
    else owner = c_on ? OWN_CPU : OWN_DBG;
    addr   = (owner == OWN_CPU) ? c_addr : g_addr;
    eff_we = (owner == OWN_CPU) && we;
    is_io  = (addr[31:28] >= 4'hE);
    w      = is_io ? io_wait_of(d) : ram_wait_of(d);
    idx    = is_io ? int'(addr[7:2]) : int'(addr[11:2]);
    exp_rd = is_io ? ref_io[idx] : ref_ram[idx];

    sel = d;
    cpu_req = c_on; cpu_we = we; cpu_addr = c_addr; cpu_wdata = wd;
    dbg_req = g_on; dbg_addr = g_addr;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; dbg_addr = $urandom;

    for (int k = 1; k <= 3 + w; k++) begin
      @(negedge clk);
      exp_v = '0;
      if (k <= 1 + w)
        exp_v = {2'b01, 2'(owner), is_io, (k == 1) && eff_we && !is_io,
                 (k == 1) && eff_we && is_io, 2'b00};
      else if (k == 2 + w)
        exp_v = {2'b10, 2'(owner), 3'b000, owner == OWN_CPU, owner == OWN_DBG};
      obs = {state_out[d], grant[d], io_sel[d], ram_we[d], io_we[d], cpu_ready[d], dbg_ready[d]};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL %s ctl d=%0d cycle %0d addr=%h: got %b want %b (state,grant,io_sel,ram_we,io_we,cpu_rdy,dbg_rdy)",
                 tag, d, k, addr, obs, exp_v);
      end
      if (k == 1) begin
        tests_run++;
        if (is_io ? (io_addr[d] !== addr[7:2]) : (ram_addr[d] !== addr[11:2])) begin
          tests_failed++;
          $display("FAIL %s index d=%0d addr=%h: ram_addr=%h io_addr=%h want idx %0d",
                   tag, d, addr, ram_addr[d], io_addr[d], idx);
        end
        if (eff_we) begin
          got_wd = is_io ? io_wdata[d] : ram_wdata[d];
          tests_run++;
          if (got_wd !== wd) begin
            tests_failed++;
            $display("FAIL %s wdata d=%0d: got %h want %h", tag, d, got_wd, wd);
          end
        end
      end
      if (k == 2 + w && !eff_we) begin
        tests_run++;
        if (cpu_rdata[d] !== exp_rd || dbg_rdata[d] !== exp_rd) begin
          tests_failed++;
          $display("FAIL %s rdata d=%0d addr=%h: cpu %h dbg %h want %h",
                   tag, d, addr, cpu_rdata[d], dbg_rdata[d], exp_rd);
        end
      end
    end
    if (eff_we) begin
      if (is_io) ref_io[idx] = wd;
      else ref_ram[idx] = wd;
    end
    last_owner = owner;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      apply_reset(d);
      @(negedge clk);
      tests_run++;
      if ({state_out[d], grant[d]} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_state d=%0d: state=%b grant=%b want 00 00", d, state_out[d], grant[d]);
      end
      tests_run++;
      if ({io_sel[d], ram_we[d], io_we[d], cpu_ready[d], dbg_ready[d]} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_strobes d=%0d: got %b want 00000", d,
                 {io_sel[d], ram_we[d], io_we[d], cpu_ready[d], dbg_ready[d]});
      end
      tests_run++;
      if (cpu_rdata[d] !== 32'h0 || dbg_rdata[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rdata d=%0d: cpu %h dbg %h want 0", d, cpu_rdata[d], dbg_rdata[d]);
      end
      tests_run++;
      if (ram_addr[d] !== 10'h0 || io_addr[d] !== 6'h0 || ram_wdata[d] !== 32'h0 || io_wdata[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_bus d=%0d: ram_addr %h io_addr %h ram_wdata %h io_wdata %h want 0",
                 d, ram_addr[d], io_addr[d], ram_wdata[d], io_wdata[d]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_cpu_read_ram();
    apply_reset(0);
    run_single(0, 1, 0, 1, 32'h0000_0010, 32'h0, 32'h1234_5678, "ram_write");
    run_single(0, 1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, "ram_read");
    tests_run++;
    if (cpu_rdata[0] !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ram_readback: got %h want 12345678", cpu_rdata[0]);
    end
  endtask

  task automatic test_cpu_write_io();
    apply_reset(0);
    run_single(0, 1, 0, 1, 32'hE000_0008, 32'h0, 32'h0000_00A5, "io_write");
    run_single(0, 1, 0, 0, 32'hE000_0008, 32'h0, 32'h0, "io_read");
    tests_run++;
    if (cpu_rdata[0] !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL io_readback: got %h want 000000a5", cpu_rdata[0]);
    end
  endtask

  task automatic test_io_wait3();
    apply_reset(1);
    run_single(1, 1, 0, 0, 32'hF000_0000, 32'h0, 32'h0, "io_wait3_read");
    run_single(1, 1, 0, 1, 32'hE000_003C, 32'h0, 32'hCAFE_0001, "io_wait3_write");
    run_single(1, 0, 1, 0, 32'h0, 32'hE000_003C, 32'h0, "io_wait3_dbg");
    run_single(1, 1, 0, 0, 32'h0000_0FFC, 32'h0, 32'h0, "ram_wait2_read");
  endtask

  task automatic test_dbg_read();
    apply_reset(0);
    run_single(0, 0, 1, 1, 32'h0, 32'h0000_0020, 32'hFFFF_FFFF, "dbg_ram");
    run_single(0, 0, 1, 1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, "dbg_io");
    run_single(0, 0, 1, 0, 32'h0, 32'hDFFF_FFFC, 32'h0, "dbg_ram_top");
  endtask

  // Both requests held: grants alternate CPU, DBG, CPU with one access every 3+W cycles.
  task automatic test_arbitration();
    int          n;
    int          owner;
    logic [31:0] exp_rd;
    logic [3:0]  obs, exp_v;
    apply_reset(0);
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    dbg_req = 1'b1; dbg_addr = 32'h0000_0080;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (cpu_ready[0] || dbg_ready[0]) begin
        owner  = (n % 2 == 0) ? OWN_CPU : OWN_DBG;
        exp_rd = (owner == OWN_CPU) ? ref_ram[16] : ref_ram[32];
        exp_v  = {2'(owner), owner == OWN_CPU, owner == OWN_DBG};
        obs    = {grant[0], cpu_ready[0], dbg_ready[0]};
        tests_run++;
        if (obs !== exp_v || k != 3 + 4 * n || n >= 3) begin
          tests_failed++;
          $display("FAIL arb_pulse %0d at cycle %0d: got %b want %b at cycle %0d",
                   n, k, obs, exp_v, 3 + 4 * n);
        end
        tests_run++;
        if (cpu_rdata[0] !== exp_rd) begin
          tests_failed++;
          $display("FAIL arb_rdata %0d: got %h want %h", n, cpu_rdata[0], exp_rd);
        end
        n++;
        if (n == 3) begin
          cpu_req = 1'b0;
          dbg_req = 1'b0;
        end
      end
    end
    tests_run++;
    if (n != 3 || state_out[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL arb_count: got %0d pulses state %b want 3 pulses state 00", n, state_out[0]);
    end
    last_owner = OWN_CPU;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    apply_reset(0);
    run_single(0, 1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, "pre_abort_read");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state_out[0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL abort_setup: state %b want 01", state_out[0]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_init();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if ({state_out[0], grant[0], cpu_ready[0], dbg_ready[0]} !== 6'b0 || cpu_rdata[0] !== 32'h0) begin
        tests_failed++;
        $display("FAIL abort_idle cycle %0d: state %b grant %b rdy %b%b rdata %h want all 0",
                 k, state_out[0], grant[0], cpu_ready[0], dbg_ready[0], cpu_rdata[0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drop_req();
    apply_reset(0);
    run_single(0, 1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, "drop_req");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if ({state_out[0], cpu_ready[0], ram_we[0]} !== 4'b0) begin
        tests_failed++;
        $display("FAIL drop_idle cycle %0d: state %b ready %b ram_we %b want 0",
                 k, state_out[0], cpu_ready[0], ram_we[0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int d, input int n);
    apply_reset(d);
    for (int t = 0; t < n; t++) begin
      int m;
      m = $urandom_range(1, 3);
      run_single(d, m[0], m[1], 1'($urandom), rand_addr(), rand_addr(), $urandom, "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    sel = 0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    test_reset();
    test_cpu_read_ram();
    test_cpu_write_io();
    test_io_wait3();
    test_dbg_read();
    test_arbitration();
    test_reset_mid();
    test_drop_req();
    test_random(0, 40);
    test_random(1, 40);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
